muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit; companion to the single-cycle ALU in the MIPS datapath.
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles (one bit per cycle) and holds results in HI/LO.
//  Width is parametrised; signed operation is added. Start/busy/done handshake lets the
//  controller stall MFHI/MFLO until the result is ready. MTHI/MTLO write HI/LO directly.
// PARAMETERS
//  WIDTH    32   operand width; HI and LO are WIDTH bits each
//  CNT_W    6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous reset, active-high
//  start    in   1      request an operation; accepted only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//  a        in   WIDTH  multiplicand/dividend (sampled with start)
//  b        in   WIDTH  multiplier/divisor (sampled with start)
//  wr_hi    in   1      MTHI: HI <= wdata
//  wr_lo    in   1      MTLO: LO <= wdata
//  wdata    in   WIDTH  data for wr_hi/wr_lo
//  busy     out  1      operation in progress (RUN or FIX)
//  done     out  1      one-cycle pulse; HI/LO hold the new result in the same cycle
//  hi       out  WIDTH  HI register (product upper half / remainder)
//  lo       out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts
//   the operation at once; no result is written.
//  FSM: IDLE -start-> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  Edge E0, IDLE with start=1: latch op; latch |a| and |b| for signed ops, raw a and b for
//   unsigned; record result signs; busy=1 from E0.
//  RUN, edges E1..E_WIDTH: one shift-add (multiply) or restoring shift-subtract (divide)
//   step per edge.
//  FIX, edge E_WIDTH+1: apply sign correction; write hi/lo; done=1 for exactly that cycle;
//   busy=0. Latency from start edge to done = WIDTH+1 cycles (33 for WIDTH=32).
//  start while busy=1: ignored; no queueing.
//  A new start may be accepted in the cycle done=1, since the unit is already IDLE.
//  Multiply: {hi,lo} = full 2*WIDTH product.
//   MULT: two's-complement. MULTU: unsigned. No overflow is possible.
//  Divide: lo = quotient, truncated toward zero; hi = remainder, which takes the dividend's
//   sign for DIV.
//  Divide by zero (either signedness): lo = all ones, hi = a. Full latency still applies.
//  DIV of most-negative by -1: lo = most-negative (wraps), hi = 0.
//  wr_hi/wr_lo: take effect at the next edge only when IDLE and start=0. They are dropped
//   (no effect) when busy=1 or start=1. wr_hi and wr_lo may be asserted together.
//  hi/lo stay stable in all cycles except a FIX edge or an accepted write.
//  done is never asserted outside the FIX->IDLE transition.
// TESTING
//  MULTU a=FFFFFFFF, b=FFFFFFFF -> 33 cycles after start: done=1, hi=FFFFFFFE,
//   lo=00000001; busy high for the 33 cycles.
//  MULT a=FFFFFFFD (-3), b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1.
//  DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  DIVU a=00000064, b=0 -> lo=FFFFFFFF, hi=00000064.
//  DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
//  Control checks:
//   - DIVU 100/7 in progress; second start at cycle 5 plus wr_hi=1 -> both ignored;
//     result lo=0000000E, hi=00000002.
//   - rst at cycle 10 of a MULT -> busy=0, done=0, hi=lo=0 next cycle; no done pulse follows.
//   - After rst, wr_lo with wdata=12345678 -> lo=12345678.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module     : muldiv_unit
// Description: Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers,
//              one bit per cycle, plus direct MTHI/MTLO writes.
// Revision   : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [1:0]       OP_MULT  = 2'b00;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;
    logic [WIDTH-1:0] opb_q,   opb_d;
    logic [WIDTH-1:0] mq_q,    mq_d;
    logic [WIDTH:0]   acc_q,   acc_d;
    logic             neg_q,   neg_d;
    logic             sgn_a_q, sgn_a_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic             done_q,  done_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Signed ops run on magnitudes; signs are restored in FIX.
    assign a_abs = (!op[0] && a[WIDTH-1]) ? -a : a;
    assign b_abs = (!op[0] && b[WIDTH-1]) ? -b : b;

    assign mul_sum   = acc_q + (mq_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    assign prod_raw = {acc_q[WIDTH-1:0], mq_q};
    assign prod_fix = (op_q == OP_MULT && neg_q) ? -prod_raw : prod_raw;
    // A zero divisor leaves quotient all ones and remainder |a|; the dividend
    // sign fix on the remainder then reproduces a exactly.
    assign quo_fix  = (opb_q == '0) ? '1 : (neg_q ? -mq_q : mq_q);
    assign rem_fix  = sgn_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opb_q   <= '0;
            mq_q    <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            sgn_a_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
            mq_q    <= mq_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            sgn_a_q <= sgn_a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        opb_d   = opb_q;
        mq_d    = mq_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        sgn_a_d = sgn_a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    neg_d   = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                    sgn_a_d = !op[0] && a[WIDTH-1];
                    if (op[1]) begin
                        mq_d  = a_abs;
                        opb_d = b_abs;
                    end else begin
                        mq_d  = b_abs;
                        opb_d = a_abs;
                    end
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[1]) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff;
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift;
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {1'b0, mul_sum[WIDTH:1]};
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                done_d = 1'b1;
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_FIX);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_muldiv_unit
// Description: Scoreboard bench for muldiv_unit with directed vectors.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         wr_hi, wr_lo;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];
    int           exp_t_q[$];
    logic [W-1:0] m_hi, m_lo;
    int           m_t;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_hi_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                m_hi = exp_hi_q.pop_front();
                m_lo = exp_lo_q.pop_front();
                m_t  = exp_t_q.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, m_hi});
                chk("lo", {32'd0, lo}, {32'd0, m_lo});
                chk("done_cycle", 64'(cyc), 64'(m_t));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0;
        exp_hi_q.push_back(ehi);
        exp_lo_q.push_back(elo);
        exp_t_q.push_back(cyc + W + 1);
    endtask

    // Returns at the negedge where done is seen.
    task automatic wait_done(output int nbusy);
        bit seen = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) nbusy++;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);

        // Each issue after wait_done starts in the done cycle itself.
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        wait_done(n);
        chk("busy_cycles", 64'(n), 64'd33);
        issue(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        wait_done(n);
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_done(n);
        issue(2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
        wait_done(n);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        wait_done(n);
        issue(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        wait_done(n);
        issue(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
        wait_done(n);
        issue(2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        wait_done(n);

        // Start and MTHI while busy are both dropped.
        issue(2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5; wr_hi = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 start = 1'b0; wr_hi = 1'b0;
        @(negedge clk);
        chk("hi_stable_busy", {32'd0, hi}, {32'd0, 32'hFFFFFFF9});
        wait_done(n);

        // Reset partway through a MULT aborts it.
        @(posedge clk); #1;
        issue(2'b00, 32'h00000003, 32'h00000003, 32'h0, 32'h0);
        void'(exp_hi_q.pop_back());
        void'(exp_lo_q.pop_back());
        void'(exp_t_q.pop_back());
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("no_done_after_abort", 64'(n), 64'd0);

        wr_lo = 1'b1; wdata = 32'h12345678;
        @(posedge clk);
        #1 wr_lo = 1'b0;
        @(negedge clk);
        chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'h12345678});
        chk("mtlo_hi", {32'd0, hi}, 64'd0);

        // Writes alongside start are dropped; HI/LO hold until FIX.
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hAAAA5555;
        issue(2'b01, 32'd2, 32'd3, 32'h0, 32'h6);
        wr_hi = 1'b0; wr_lo = 1'b0;
        @(negedge clk);
        chk("wr_with_start_hi", {32'd0, hi}, 64'd0);
        chk("wr_with_start_lo", {32'd0, lo}, {32'd0, 32'h12345678});
        wait_done(n);

        @(posedge clk);
        #1 wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 wr_hi = 1'b0; wr_lo = 1'b0;
        @(negedge clk);
        chk("mthi_both", {32'd0, hi}, {32'd0, 32'hCAFEF00D});
        chk("mtlo_both", {32'd0, lo}, {32'd0, 32'hCAFEF00D});

        chk("scoreboard_empty", 64'(exp_hi_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
